// File: rtl/qq_pkg.sv
// qq_pkg: shared op/state encodings and default sizing for the value router.
package qq_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CAPACITY = 1024;
    typedef enum logic {OP_ENQ = 1'b0, OP_DEQ = 1'b1} op_e;
    typedef enum logic [2:0] {IDLE, PUSH, POP_OUT, REFILL_REQ, REFILL_WAIT} state_e;
endpackage

// File: rtl/qq_value_cmp.sv
// qq_value_cmp: unsigned compare deciding whether an incoming value displaces the resident head.
module qq_value_cmp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] new_i,
    input  logic [DATA_W-1:0] res_i,
    input  logic              tie_fifo_i,
    output logic              win_o
);
    // Tie-FIFO mode keeps the resident on equal values so equals leave in arrival order.
    assign win_o = tie_fifo_i ? (new_i > res_i) : (new_i >= res_i);
endmodule

// File: rtl/qq_value_router.sv
// qq_value_router: one stage of a max-priority queue; keeps the largest value in a head register.
// Define QQ_ROUTER_TIE_FIFO_EN to keep the resident head on ties (FIFO order among equals).
module qq_value_router
    import qq_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CAPACITY = DEF_CAPACITY
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_op,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic                             dn_valid,
    input  logic                             dn_ready,
    output logic                             dn_op,
    output logic [DATA_W-1:0]                dn_data,
    input  logic                             ram_valid,
    input  logic [DATA_W-1:0]                ram_data,
    output logic                             fb,
    output logic [$clog2(CAPACITY+1)-1:0]    count,
    output logic                             full,
    output logic                             empty,
    output logic                             err_full,
    output logic                             err_empty
);
    localparam int CW = $clog2(CAPACITY + 1);
    localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);
    localparam logic [CW-1:0] ONE_C = CW'(1);
`ifdef QQ_ROUTER_TIE_FIFO_EN
    localparam logic TIE_FIFO = 1'b1;
`else
    localparam logic TIE_FIFO = 1'b0;
`endif

    state_e            state_q;
    logic [DATA_W-1:0] head_q;
    logic              head_vld_q;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] dn_data_q;
    logic              fb_q;
    logic              err_full_q;
    logic              err_empty_q;
    logic              win;

    qq_value_cmp #(.DATA_W(DATA_W)) u_cmp (
        .new_i      (in_data),
        .res_i      (head_q),
        .tie_fifo_i (TIE_FIFO),
        .win_o      (win)
    );

    // Gating with rst keeps in_ready low while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == POP_OUT);
    assign out_data  = head_q;
    assign dn_valid  = (state_q == PUSH) || (state_q == REFILL_REQ);
    assign dn_op     = (state_q == REFILL_REQ);
    assign dn_data   = dn_data_q;
    assign fb        = fb_q;
    assign count     = count_q;
    assign full      = (count_q == CAP_C);
    assign empty     = (count_q == '0);
    assign err_full  = err_full_q;
    assign err_empty = err_empty_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            head_vld_q  <= 1'b0;
            count_q     <= '0;
            dn_data_q   <= '0;
            fb_q        <= 1'b0;
            err_full_q  <= 1'b0;
            err_empty_q <= 1'b0;
        end else begin
            fb_q        <= 1'b0;
            err_full_q  <= 1'b0;
            err_empty_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && in_op == OP_ENQ) begin
                        if (count_q == CAP_C) begin
                            err_full_q <= 1'b1;
                        end else if (!head_vld_q) begin
                            head_q     <= in_data;
                            head_vld_q <= 1'b1;
                            count_q    <= count_q + ONE_C;
                        end else begin
                            count_q   <= count_q + ONE_C;
                            state_q   <= PUSH;
                            head_q    <= win ? in_data : head_q;
                            dn_data_q <= win ? head_q : in_data;
                            fb_q      <= !win;
                        end
                    end else if (in_valid) begin
                        if (count_q == '0) err_empty_q <= 1'b1;
                        else state_q <= POP_OUT;
                    end
                end
                PUSH: if (dn_ready) state_q <= IDLE;
                POP_OUT: begin
                    if (out_ready) begin
                        count_q    <= count_q - ONE_C;
                        head_vld_q <= 1'b0;
                        state_q    <= (count_q == ONE_C) ? IDLE : REFILL_REQ;
                    end
                end
                REFILL_REQ: if (dn_ready) state_q <= REFILL_WAIT;
                REFILL_WAIT: begin
                    if (ram_valid) begin
                        head_q     <= ram_data;
                        head_vld_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/qq_value_router.md
QQ_VALUE_ROUTER -- requirements
Module: qq_value_router

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk rises sample state; rst asserted clears state immediately.
REQ-002 The block SHALL have these parameters:
- DATA_W, default 32, key/value width; compare is unsigned.
- CAPACITY, default 1024, max entries held in this stage plus all stages below.
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_valid  in  1  upstream request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  1  0=ENQ, 1=DEQ
- in_data  in  DATA_W  value to enqueue
- out_valid  out  1  dequeued value valid
- out_ready  in  1  consumer accepts out_data
- out_data  out  DATA_W  dequeued (largest) value
- dn_valid  out  1  request to next stage valid
- dn_ready  in  1  next stage accepts request
- dn_op  out  1  0=ENQ displaced value, 1=DEQ refill request
- dn_data  out  DATA_W  displaced value
- ram_valid  in  1  refill value returned from next stage
- ram_data  in  DATA_W  refill value
- fb  out  1  1-cycle pulse: incoming value routed downstream
- count  out  $clog2(CAPACITY+1)  entries held
- full, empty  out  1  count==CAPACITY, count==0
- err_full, err_empty  out  1  1-cycle pulse on dropped ENQ/DEQ

Function
REQ-004 The block SHALL hold the current maximum in a head register (head, head_vld).
REQ-005 FSM states SHALL be IDLE, PUSH, POP_OUT, REFILL_REQ, REFILL_WAIT; in_ready=1 only in IDLE.
REQ-006 ENQ when full SHALL be dropped, err_full pulses, state stays IDLE.
REQ-007 ENQ with head_vld=0 SHALL load head in one cycle, count+1, stay IDLE.
REQ-008 ENQ with head_vld=1: if in_data wins compare, in_data->head and old head->dn_data; else in_data->dn_data; fb=1 in the loser-routing cycle only when in_data loses; count+1; go PUSH.
REQ-009 PUSH SHALL hold dn_valid=1, dn_op=0, dn_data stable until dn_ready, then IDLE.
REQ-010 DEQ when empty SHALL be dropped, err_empty pulses, stays IDLE.
REQ-011 DEQ accepted SHALL present head on out_data with out_valid=1 next cycle (POP_OUT), stable until out_ready; count-1 on out_ready handshake.
REQ-012 On POP_OUT handshake: if count was 1, head_vld<=0 and IDLE; else go REFILL_REQ.
REQ-013 REFILL_REQ SHALL hold dn_valid=1, dn_op=1 until dn_ready, then REFILL_WAIT.
REQ-014 REFILL_WAIT SHALL load ram_data into head on ram_valid and return to IDLE; ram_valid in any other state SHALL be ignored.
REQ-015 Simultaneous out_ready and dn_ready SHALL only affect the state currently waiting on them.

Reset
REQ-016 rst SHALL force IDLE, head_vld=0, head=0, count=0, empty=1, and all other outputs 0 (in_ready=1 after release); in-flight PUSH/REFILL transactions are discarded.

Configuration
REQ-017 With QQ_ROUTER_TIE_FIFO_EN defined, in_data SHALL win only if in_data > head (resident kept on tie, FIFO order among equals); without it, in_data SHALL win if in_data >= head.

Structure
REQ-018 Package qq_pkg SHALL hold the op enum (ENQ/DEQ), the FSM state enum and default DATA_W/CAPACITY constants.
REQ-019 The compare SHALL be a sub-module qq_value_cmp (DATA_W, tie mode input) producing win.

Verification (DATA_W=8, CAPACITY=4)
REQ-020 Reset, ENQ 0x10 -> head=0x10, count=1, no dn_valid, fb=0.
REQ-021 Head 0x10, ENQ 0x30 -> head=0x30, dn_valid with dn_data=0x10, dn_ready delayed 3 cycles keeps dn_data stable; ENQ 0x05 -> fb=1, dn_data=0x05.
REQ-022 Head 0x20, ENQ 0x20 -> dn_data=new 0x20 with macro, old 0x20 without (tag via bench-side tracking).
REQ-023 count=2, DEQ -> out_data=head, out_valid held through 2 stalled cycles, then dn_op=1, ram_data=0x07 -> head=0x07, count=1.
REQ-024 count=4 ENQ -> err_full pulse, count 4; count=0 DEQ -> err_empty pulse.
REQ-025 rst asserted in REFILL_WAIT -> all outputs 0 same cycle, later ram_valid ignored.
